mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Accepts the same two 32-bit operands the ALU receives, then runs MULT/MULTU/DIV/DIVU over a fixed number of cycles.
- Results are committed to internal HI/LO registers; MTHI/MTLO write HI/LO directly.
- Busy drives the hazard/stall unit, which stalls any MDU instruction or HI/LO read while Start or Busy is high.

---
 rtl/mdu_defs.sv | 22 ++
 rtl/mdu_calc.sv | 75 +++++++
 rtl/mdu_unit.sv | 111 +++++++++++
 tb/tb_mdu_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and FSM state encodings.
package mdu_defs;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: 64-bit {hi,lo} for the four arithmetic
// operations plus a divide-by-zero flag. No state; timing lives in mdu_unit.
module mdu_calc
    import mdu_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic        is_signed_div;
    logic [31:0] divd;
    logic [31:0] dvsr;
    logic [31:0] dvsr_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;

    // Signed product: the low 64 bits of a product of sign-extended operands
    // equal the two's-complement signed product, so no signed types needed.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes and fixes signs afterwards; this
    // makes 0x80000000 / -1 fall out naturally as 0x80000000 remainder 0.
    assign neg_a         = a[31];
    assign neg_b         = b[31];
    assign is_signed_div = (op == MDU_DIV);
    assign divd          = (is_signed_div && neg_a) ? (32'd0 - a) : a;
    assign dvsr          = (is_signed_div && neg_b) ? (32'd0 - b) : b;
    // Divisor forced non-zero so the divider never sees x/0; the flag below
    // tells the caller to discard the result.
    assign dvsr_safe     = (dvsr == 32'd0) ? 32'd1 : dvsr;
    assign quo_mag       = divd / dvsr_safe;
    assign rem_mag       = divd % dvsr_safe;

    // Select the result for the requested operation.
    always_comb begin
        hi          = 32'd0;
        lo          = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MDU_DIV: begin
                lo          = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
                hi          = neg_a ? (32'd0 - rem_mag) : rem_mag;
                div_by_zero = (b == 32'd0);
            end
            MDU_DIVU: begin
                lo          = quo_mag;
                hi          = rem_mag;
                div_by_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit. The result is computed at the start edge
// and held in temp registers; HI/LO are committed when the busy counter
// expires, so Busy models the real unit's latency for the stall logic.
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDUIn1,
    input  logic [31:0] MDUIn2,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state_reg,   state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [31:0] temp_hi_reg, temp_hi_next;
    logic [31:0] temp_lo_reg, temp_lo_next;
    logic        temp_dbz_reg, temp_dbz_next;
    logic [31:0] hi_reg,      hi_next;
    logic [31:0] lo_reg,      lo_next;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_dbz;

    mdu_calc u_calc (
        .a           (MDUIn1),
        .b           (MDUIn2),
        .op          (MDUOp),
        .hi          (calc_hi),
        .lo          (calc_lo),
        .div_by_zero (calc_dbz)
    );

    // State, counter and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            temp_hi_reg  <= 32'd0;
            temp_lo_reg  <= 32'd0;
            temp_dbz_reg <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            temp_hi_reg  <= temp_hi_next;
            temp_lo_reg  <= temp_lo_next;
            temp_dbz_reg <= temp_dbz_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    // Next-state: accept work in IDLE, count down in RUN, commit on expiry.
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        temp_hi_next  = temp_hi_reg;
        temp_lo_next  = temp_lo_reg;
        temp_dbz_next = temp_dbz_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            temp_hi_next  = calc_hi;
                            temp_lo_next  = calc_lo;
                            temp_dbz_next = calc_dbz;
                            counter_next  = MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state_next    = RUN;
                        end
                        MDU_MTHI: hi_next = MDUIn1;
                        MDU_MTLO: lo_next = MDUIn1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start is deliberately not looked at here.
                counter_next = counter_reg - CNT_W'(1);
                if (counter_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    if (!temp_dbz_reg) begin
                        hi_next = temp_hi_reg;
                        lo_next = temp_lo_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state_reg == RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Testbench for mdu_unit: directed cases with literal expectations followed
// by a randomized stream, all checked every cycle against a behavioural model.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] MDUIn1;
    logic [31:0] MDUIn2;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .MDUIn1 (MDUIn1),
        .MDUIn2 (MDUIn2),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic with 64-bit integers: {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     p;
        case (op)
            3'd0: begin p = sa * sb; return {1'b0, p}; end
            3'd1: begin p = ua * ub; return {1'b0, p}; end
            3'd2: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    // Behavioural model: remaining busy cycles plus pending and visible HI/LO.
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_dbz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem <= 0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && !p_dbz) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (Start) begin
            if (MDUOp <= 3'd3) begin
                {p_dbz, p_hi, p_lo} <= ref_result(MDUOp, MDUIn1, MDUIn2);
                m_rem <= (MDUOp <= 3'd1) ? 5 : 10;
            end else if (MDUOp == 3'd4) begin
                m_hi <= MDUIn1;
            end else if (MDUOp == 3'd5) begin
                m_lo <= MDUIn1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if (Busy !== (m_rem > 0) || HI !== m_hi || LO !== m_lo) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got Busy=%b HI=%h LO=%h, expected Busy=%b HI=%h LO=%h",
                         $time, Busy, HI, LO, (m_rem > 0), m_hi, m_lo);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Issue one Start pulse, then count busy cycles until Busy falls.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit toggle, output int busy_cycles);
        @(negedge clk);
        MDUOp  = op;
        MDUIn1 = a;
        MDUIn2 = b;
        Start  = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 100) begin
            busy_cycles++;
            if (toggle) begin
                MDUIn1 = $urandom;
                MDUIn2 = $urandom;
            end
            @(negedge clk);
        end
        $display("op=%0d a=%h b=%h busy=%0d HI=%h LO=%h", op, a, b, busy_cycles, HI, LO);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    int bc;

    initial begin
        reset  = 1'b0;
        Start  = 1'b0;
        MDUOp  = 3'b111;
        MDUIn1 = 32'd0;
        MDUIn2 = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_lit("reset_busy", {31'd0, Busy}, 32'd0);
        check_lit("reset_hi", HI, 32'd0);
        check_lit("reset_lo", LO, 32'd0);

        // Abort a MULT with reset: no HI/LO update may follow.
        @(negedge clk);
        MDUOp = 3'd0; MDUIn1 = 32'd5; MDUIn2 = 32'd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_lit("abort_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check_lit("abort_hi", HI, 32'd0);
        check_lit("abort_lo", LO, 32'd0);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, bc);
        check_lit("mult_busy", bc, 32'd5);
        check_lit("mult_hi", HI, 32'hFFFF_FFFF);
        check_lit("mult_lo", LO, 32'hFFFF_FFFA);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, bc);
        check_lit("multu_hi", HI, 32'h0000_0002);
        check_lit("multu_lo", LO, 32'hFFFF_FFFA);

        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
        check_lit("div_busy", bc, 32'd10);
        check_lit("div_lo", LO, 32'hFFFF_FFFD);
        check_lit("div_hi", HI, 32'hFFFF_FFFF);
        do_op(3'd3, 32'd7, 32'd2, 1'b0, bc);
        check_lit("divu_lo", LO, 32'd3);
        check_lit("divu_hi", HI, 32'd1);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
        check_lit("divovf_lo", LO, 32'h8000_0000);
        check_lit("divovf_hi", HI, 32'd0);

        do_op(3'd4, 32'h1234, 32'd0, 1'b0, bc);
        do_op(3'd5, 32'h5678, 32'd0, 1'b0, bc);
        do_op(3'd3, 32'd5, 32'd0, 1'b0, bc);
        check_lit("dbz_busy", bc, 32'd10);
        check_lit("dbz_hi", HI, 32'h1234);
        check_lit("dbz_lo", LO, 32'h5678);

        do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, bc);
        check_lit("mthi_busy", bc, 32'd0);
        check_lit("mthi_hi", HI, 32'hDEAD_BEEF);
        check_lit("mthi_lo", LO, 32'h5678);

        // MULT 2x3 with an MTLO Start issued while busy; it must be ignored.
        @(negedge clk);
        MDUOp = 3'd0; MDUIn1 = 32'd2; MDUIn2 = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        MDUOp = 3'd5; MDUIn1 = 32'hAAAA; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        bc = 0;
        while (Busy && bc < 100) begin bc++; @(negedge clk); end
        check_lit("midrun_hi", HI, 32'd0);
        check_lit("midrun_lo", LO, 32'd6);

        do_op(3'd3, 32'd100, 32'd7, 1'b1, bc);
        check_lit("toggle_lo", LO, 32'd14);
        check_lit("toggle_hi", HI, 32'd2);

        // Random stream, including Starts during RUN and undefined ops.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            Start  = ($urandom_range(0, 3) == 0);
            MDUOp  = 3'($urandom_range(0, 7));
            MDUIn1 = pick_operand();
            MDUIn2 = pick_operand();
        end
        @(negedge clk);
        Start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
